// File: rtl/down_cnt_pkg.sv
// Shared definitions for the down-counter timer: FSM state encoding and default width.
// The optional DOWN_CNT_AUTO_RELOAD_EN macro is consumed by the top, not here.
package down_cnt_pkg;

    localparam int DOWN_CNT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/down_cnt_core.sv
// Count register with synchronous load and a saturating decrement.
// Also provides the zero and one detects that the controlling FSM relies on.
module down_cnt_core
    import down_cnt_pkg::*;
#(
    parameter int WIDTH = DOWN_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_o,
    output logic             is_zero_o,
    output logic             is_one_o
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        // NOTE: default first so every path assigns q_d; otherwise a latch is inferred.
        q_d = q_q;
        if (ld_i) begin
            q_d = ld_val_i;
        end else if (dec_i && !is_zero_o) begin
            q_d = q_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment for state so all flops sample pre-edge values.
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o       = q_q;
    assign is_zero_o = (q_q == '0);
    assign is_one_o  = (q_q == WIDTH'(1));

endmodule

// File: rtl/async_down_counter_timer.sv
// Loadable down-counter timer: IDLE/RUN/DONE FSM with a one-cycle terminal-count pulse.
// Define DOWN_CNT_AUTO_RELOAD_EN to restart from the last loaded value after DONE.
module async_down_counter_timer
    import down_cnt_pkg::*;
#(
    parameter int WIDTH = DOWN_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    state_e           state_d, state_q;
    logic             core_ld;
    logic [WIDTH-1:0] core_ld_val;
    logic             core_dec;
    logic             q_is_zero;
    logic             q_is_one;

`ifdef DOWN_CNT_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_d, reload_q;

    assign reload_d = load ? load_val : reload_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        core_ld     = 1'b0;
        core_ld_val = load_val;
        core_dec    = 1'b0;
        if (load) begin
            core_ld = 1'b1;
            state_d = (load_val == '0) ? IDLE : RUN;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    // A zero count in RUN is unreachable; fall back to IDLE rather than wrap.
                    if (q_is_zero) begin
                        state_d = IDLE;
                    end else if (en) begin
                        core_dec = 1'b1;
                        if (q_is_one) state_d = DONE;
                    end
                end
                DONE: begin
`ifdef DOWN_CNT_AUTO_RELOAD_EN
                    core_ld     = 1'b1;
                    core_ld_val = reload_q;
                    state_d     = (reload_q == '0) ? IDLE : RUN;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    down_cnt_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_i     (core_ld),
        .ld_val_i (core_ld_val),
        .dec_i    (core_dec),
        .q_o      (q),
        .is_zero_o(q_is_zero),
        .is_one_o (q_is_one)
    );

    assign tc   = (state_q == DONE);
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_async_down_counter_timer.sv
// Scoreboard bench for async_down_counter_timer (WIDTH=3), directed vectors.
// Expected values switch with DOWN_CNT_AUTO_RELOAD_EN so both builds are covered.
module tb_async_down_counter_timer;

    localparam int WIDTH = 3;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        logic             tc;
        logic             busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    async_down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .load_val(load_val),
        .en      (en),
        .q       (q),
        .tc      (tc),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {q,tc,busy}=%0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string name, input logic ld, input logic [WIDTH-1:0] val,
                        input logic e, input logic [WIDTH-1:0] eq, input logic etc,
                        input logic ebusy);
        exp_t item;
        @(negedge clk);
        load     = ld;
        load_val = val;
        en       = e;
        item.name = name;
        item.q    = eq;
        item.tc   = etc;
        item.busy = ebusy;
        sb.push_back(item);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, {27'd0, q, tc, busy}, {27'd0, e.q, e.tc, e.busy});
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;

        // Asynchronous reset, no clock edge needed.
        #2 rst_n = 1'b0;
        #1 check("reset_async", {27'd0, q, tc, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step("idle_ignores_en", 0, 0, 1, 0, 0, 0);

        // Load 5, count to zero.
        step("ld5_q5", 1, 5, 1, 5, 0, 1);
        step("ld5_q4", 0, 0, 1, 4, 0, 1);
        step("ld5_q3", 0, 0, 1, 3, 0, 1);
        step("ld5_q2", 0, 0, 1, 2, 0, 1);
        step("ld5_q1", 0, 0, 1, 1, 0, 1);
        step("ld5_tc", 0, 0, 1, 0, 1, 0);
        step("ld5_after_done", 0, 0, 1, AR ? 3'd5 : 3'd0, 0, AR);

        // Load 3 with en pattern 1,0,0,1,1.
        step("ld3_q3", 1, 3, 0, 3, 0, 1);
        step("ld3_en1_q2", 0, 0, 1, 2, 0, 1);
        step("ld3_en0_hold_a", 0, 0, 0, 2, 0, 1);
        step("ld3_en0_hold_b", 0, 0, 0, 2, 0, 1);
        step("ld3_en1_q1", 0, 0, 1, 1, 0, 1);
        step("ld3_en1_tc", 0, 0, 1, 0, 1, 0);
        step("ld3_done_ignores_en", 0, 0, 0, AR ? 3'd3 : 3'd0, 0, AR);

        // Load 0 stays IDLE; reload 7 mid-count.
        step("ld0_idle", 1, 0, 1, 0, 0, 0);
        step("ld0_no_tc_a", 0, 0, 1, 0, 0, 0);
        step("ld0_no_tc_b", 0, 0, 1, 0, 0, 0);
        step("ld6_q6", 1, 6, 1, 6, 0, 1);
        step("ld6_q5", 0, 0, 1, 5, 0, 1);
        step("ld6_q4", 0, 0, 1, 4, 0, 1);
        step("ld7_at_q4", 1, 7, 1, 7, 0, 1);
        step("ld7_q6", 0, 0, 1, 6, 0, 1);
        step("ld7_q5", 0, 0, 1, 5, 0, 1);

        // Load 2: periodic with auto-reload, parked at 0 without it.
        step("ld2_q2", 1, 2, 1, 2, 0, 1);
        step("ld2_q1", 0, 0, 1, 1, 0, 1);
        step("ld2_tc", 0, 0, 1, 0, 1, 0);
        step("ld2_p2_q2", 0, 0, 1, AR ? 3'd2 : 3'd0, 0, AR);
        step("ld2_p2_q1", 0, 0, 1, AR ? 3'd1 : 3'd0, 0, AR);
        step("ld2_p2_tc", 0, 0, 1, 0, AR, 0);

        // Long hold with en low; max load value.
        step("ld7_hold_q7", 1, 7, 0, 7, 0, 1);
        step("hold_a", 0, 0, 0, 7, 0, 1);
        step("hold_b", 0, 0, 0, 7, 0, 1);
        step("hold_c", 0, 0, 0, 7, 0, 1);
        step("ld7_q6_after_hold", 0, 0, 1, 6, 0, 1);

        // Load during DONE overrides the reload value.
        step("ld1_q1", 1, 1, 1, 1, 0, 1);
        step("ld1_tc", 0, 0, 1, 0, 1, 0);
        step("ld6_in_done", 1, 6, 1, 6, 0, 1);
        step("ovr_q5", 0, 0, 1, 5, 0, 1);
        step("ovr_q4", 0, 0, 1, 4, 0, 1);
        step("ovr_q3", 0, 0, 1, 3, 0, 1);
        step("ovr_q2", 0, 0, 1, 2, 0, 1);
        step("ovr_q1", 0, 0, 1, 1, 0, 1);
        step("ovr_tc", 0, 0, 1, 0, 1, 0);
        step("ovr_reload6", 0, 0, 1, AR ? 3'd6 : 3'd0, 0, AR);

        // Reset mid-count aborts; block waits in IDLE.
        step("mid_ld5", 1, 5, 1, 5, 0, 1);
        step("mid_q4", 0, 0, 1, 4, 0, 1);
        @(negedge clk);
        load  = 1'b0;
        en    = 1'b1;
        rst_n = 1'b0;
        #1 check("reset_mid_count", {27'd0, q, tc, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_idle_a", 0, 0, 1, 0, 0, 0);
        step("post_reset_idle_b", 0, 0, 1, 0, 0, 0);
        step("post_reset_ld2", 1, 2, 1, 2, 0, 1);
        step("post_reset_q1", 0, 0, 1, 1, 0, 1);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
